vector_sequencer: RTL and testbench
===================================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 VLEN, default 4, elements per vector register; power of 2, 2..16; EW = log2(VLEN).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  valid vector instruction offered by execute stage.
REQ-005 opcode  input  4  instruction opcode.
REQ-006 ra  input  4  first source vector register.
REQ-007 rb  input  4  second source vector register.
REQ-008 rt  input  4  destination register, vector or scalar.
REQ-009 base_addr  input  16  memory base for vld/vst.
REQ-010 busy  output  1  sequencer occupied; pipeline stall request.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 vrf_raddr_a  output  4+EW  vector read address {reg,elem}, port A.
REQ-013 vrf_raddr_b  output  4+EW  vector read address {reg,elem}, port B.
REQ-014 vrf_rdata_a  input  16  combinational read data, port A.
REQ-015 vrf_rdata_b  input  16  combinational read data, port B.
REQ-016 wb_vwe  output  1  vector register element write enable.
REQ-017 wb_swe  output  1  scalar register write enable.
REQ-018 wb_addr  output  4+EW  write address {reg,elem}; scalar writes use {rt,0}.
REQ-019 wb_data  output  16  write data.
REQ-020 mem_req  output  1  memory request.
REQ-021 mem_we  output  1  1 = store, 0 = load.
REQ-022 mem_addr  output  16  memory word address.
REQ-023 mem_wdata  output  16  store data.
REQ-024 mem_gnt  input  1  request accepted this cycle.
REQ-025 mem_rdata  input  16  load data, valid the cycle after mem_gnt.

Function
REQ-026 Opcodes: vadd 1000, vsub 1001, vmul 1010, vdiv 1011, vld 1100, vst 1101, vdot 1110.
REQ-027 States IDLE, EXEC, MEM, WAIT, DONE; element counter i runs 0..VLEN-1.
REQ-028 start is accepted only in IDLE; opcode/ra/rb/rt/base_addr are captured on acceptance and ignored afterwards; start is ignored while busy.
REQ-029 busy = 1 in every non-IDLE state; done = 1 only in DONE; DONE always returns to IDLE next cycle.
REQ-030 vadd/vsub/vmul: in EXEC, one element per cycle: vrf_raddr_a = {ra,i}, vrf_raddr_b = {rb,i}, wb_vwe = 1, wb_addr = {rt,i}, wb_data = a+b, a-b, or a*b[15:0]; all results are mod 2^16.
REQ-031 vadd/vsub/vmul run VLEN EXEC cycles then DONE; done asserts VLEN+1 cycles after the accepting edge.
REQ-032 vdot: EXEC accumulates acc = acc + a*b (mod 2^16) per element with no vector writes; in DONE, wb_swe = 1, wb_addr = {rt,0}, wb_data = final acc including the last element.
REQ-033 vld: MEM drives mem_req = 1, mem_we = 0, mem_addr = base+i (mod 2^16) until mem_gnt; WAIT then writes wb_vwe = 1, {rt,i}, mem_rdata; next state is MEM for i+1, or DONE after the last element.
REQ-034 vst: MEM drives mem_req = 1, mem_we = 1, mem_addr = base+i, vrf_raddr_a = {ra,i}, mem_wdata = vrf_rdata_a; i advances on mem_gnt, with back-to-back elements under continuous grant; DONE follows the last grant.
REQ-035 mem_req, mem_we, mem_addr and mem_wdata are held stable from request until grant.
REQ-036 vdiv and undefined opcodes: go straight to DONE with no writes or memory requests.
REQ-037 Enables (wb_vwe, wb_swe, mem_req, mem_we) are 0, and addresses/data are 0, whenever not driven by the rules above.

Reset
REQ-038 rst asynchronously forces IDLE, i = 0, acc = 0, captured fields = 0, and all outputs = 0, independent of clk.
REQ-039 rst during an operation aborts it with no further writes or requests; the first start is accepted on the first rising edge with rst low.

Structure
REQ-040 Shared package vec_pkg holds the opcode constants, the state enumeration, VLEN default and data width 16.
REQ-041 One sub-module, vseq_lane_alu: combinational add/sub/mul lane, reused for vdot multiply.

Verification
REQ-042 VLEN=4, vadd ra=1 rb=2 rt=3, v1={1,2,3,4}, v2={10,20,30,40} -> {3,0..3} written {11,22,33,44} on 4 consecutive cycles; done on 5th cycle.
REQ-043 vdot v1={1,2,3,4}, v2={5,6,7,8} -> single wb_swe with wb_data = 70 to {rt,0}; wb_vwe never asserted.
REQ-044 vld base=0xFFFE, grant delayed 2 cycles per element -> addresses FFFE, FFFF, 0000, 0001; request stable while waiting; rdata written to {rt,i}.
REQ-045 vst with mem_gnt tied high -> 4 store cycles back-to-back at base..base+3, data = va elements; done the following cycle.
REQ-046 vmul 0x0100*0x0100 -> 0x0000; vsub 3-5 -> 0xFFFE; vdiv -> done next cycle with no writes.
REQ-047 rst asserted during element 2 of vadd -> outputs 0 immediately with no element 3 write; start pulsed while busy is ignored.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared opcodes, FSM states, ALU ops and widths for the vector sequencer
package vec_pkg;

  localparam int VLEN_DEF = 4;
  localparam int DW       = 16;

  localparam logic [3:0] OP_VADD = 4'b1000;
  localparam logic [3:0] OP_VSUB = 4'b1001;
  localparam logic [3:0] OP_VMUL = 4'b1010;
  localparam logic [3:0] OP_VDIV = 4'b1011;
  localparam logic [3:0] OP_VLD  = 4'b1100;
  localparam logic [3:0] OP_VST  = 4'b1101;
  localparam logic [3:0] OP_VDOT = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_MUL
  } alu_op_e;

endpackage

// File: rtl/vseq_lane_alu.sv
// rtl/vseq_lane_alu.sv - combinational 16-bit add/sub/mul lane
// Ports:
//   op  - lane operation (add, sub, mul)
//   a,b - element operands
//   y   - result, truncated to 16 bits (mod 2^16)
module vseq_lane_alu
  import vec_pkg::*;
(
  input  alu_op_e       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_MUL: y = a * b;  // low 16 bits of the product
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - element-serial sequencer for vector ALU, dot product, load and store
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start, opcode, ra, rb,   - instruction offer from execute; captured only when idle
//   rt, base_addr
//   busy, done               - stall request, one-cycle completion pulse
//   vrf_raddr_a/b, vrf_rdata_a/b - vector register file read ports {reg,elem}
//   wb_vwe, wb_swe, wb_addr, wb_data - vector element / scalar writeback
//   mem_req, mem_we, mem_addr, mem_wdata, mem_gnt, mem_rdata - memory port
module vector_sequencer
  import vec_pkg::*;
#(
  parameter  int VLEN = VLEN_DEF,
  localparam int EW   = $clog2(VLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      opcode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rt,
  input  logic [DW-1:0]   base_addr,
  output logic            busy,
  output logic            done,
  output logic [4+EW-1:0] vrf_raddr_a,
  output logic [4+EW-1:0] vrf_raddr_b,
  input  logic [DW-1:0]   vrf_rdata_a,
  input  logic [DW-1:0]   vrf_rdata_b,
  output logic            wb_vwe,
  output logic            wb_swe,
  output logic [4+EW-1:0] wb_addr,
  output logic [DW-1:0]   wb_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic [DW-1:0]   mem_rdata
);

  state_e        state_q, state_d;
  logic [EW-1:0] i_q, i_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [3:0]    op_q, op_d, ra_q, ra_d, rb_q, rb_d, rt_q, rt_d;
  logic [DW-1:0] base_q, base_d;

  alu_op_e       alu_op;
  logic [DW-1:0] alu_y;
  logic          last;
  logic          is_vdot;

  assign last    = (i_q == EW'(VLEN - 1));
  assign is_vdot = (op_q == OP_VDOT);

  // vdot reuses the multiply lane; only vadd/vsub pick a different op
  always_comb begin
    alu_op = ALU_MUL;
    if (op_q == OP_VADD)      alu_op = ALU_ADD;
    else if (op_q == OP_VSUB) alu_op = ALU_SUB;
  end

  vseq_lane_alu u_alu (
    .op (alu_op),
    .a  (vrf_rdata_a),
    .b  (vrf_rdata_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rt_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rt_q    <= rt_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    acc_d   = acc_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rt_d    = rt_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = opcode;
          ra_d   = ra;
          rb_d   = rb;
          rt_d   = rt;
          base_d = base_addr;
          i_d    = '0;
          acc_d  = '0;
          case (opcode)
            OP_VADD, OP_VSUB, OP_VMUL, OP_VDOT: state_d = ST_EXEC;
            OP_VLD, OP_VST:                     state_d = ST_MEM;
            OP_VDIV:                            state_d = ST_DONE;
            default:                            state_d = ST_DONE;
          endcase
        end
      end
      ST_EXEC: begin
        if (is_vdot) acc_d = acc_q + alu_y;
        if (last) state_d = ST_DONE;
        else      i_d     = i_q + 1'b1;
      end
      ST_MEM: begin
        if (mem_gnt) begin
          if (op_q == OP_VLD) state_d = ST_WAIT;  // load data arrives next cycle
          else if (last)      state_d = ST_DONE;
          else                i_d     = i_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (last) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = ST_MEM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        i_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is decoded from registered state, so reset zeroes them at once
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    vrf_raddr_a = '0;
    vrf_raddr_b = '0;
    wb_vwe      = 1'b0;
    wb_swe      = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      ST_EXEC: begin
        vrf_raddr_a = {ra_q, i_q};
        vrf_raddr_b = {rb_q, i_q};
        if (!is_vdot) begin
          wb_vwe  = 1'b1;
          wb_addr = {rt_q, i_q};
          wb_data = alu_y;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = base_q + DW'(i_q);
        if (op_q == OP_VST) begin
          mem_we      = 1'b1;
          vrf_raddr_a = {ra_q, i_q};
          mem_wdata   = vrf_rdata_a;
        end
      end
      ST_WAIT: begin
        wb_vwe  = 1'b1;
        wb_addr = {rt_q, i_q};
        wb_data = mem_rdata;
      end
      ST_DONE: begin
        done = 1'b1;
        if (is_vdot) begin
          wb_swe  = 1'b1;
          wb_addr = {rt_q, {EW{1'b0}}};
          wb_data = acc_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - scoreboard bench for vector_sequencer at VLEN=4
module tb_vector_sequencer;
  import vec_pkg::*;

  localparam int VL = 4;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, start = 1'b0;
  logic [3:0]    opcode = '0, ra = '0, rb = '0, rt = '0;
  logic [15:0]   base_addr = '0;
  logic          busy, done, wb_vwe, wb_swe, mem_req, mem_we, mem_gnt;
  logic [AW-1:0] vrf_raddr_a, vrf_raddr_b, wb_addr;
  logic [15:0]   vrf_rdata_a, vrf_rdata_b, wb_data, mem_addr, mem_wdata;
  logic [15:0]   mem_rdata = '0;
  logic [15:0]   vrf [64];

  int vectors = 0, miscompares = 0;
  int cyc = 0, base_cyc = 0;
  bit gnt_always = 1'b0;
  int gnt_delay = 2, wait_cnt = 0;

  typedef struct {logic swe; logic [AW-1:0] addr; logic [15:0] data; int off;} wr_t;
  typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata; int off;} mr_t;
  wr_t wq[$];
  mr_t mq[$];
  wr_t we_e;
  mr_t me_e;

  vector_sequencer #(.VLEN(VL)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ra(ra), .rb(rb), .rt(rt),
    .base_addr(base_addr), .busy(busy), .done(done),
    .vrf_raddr_a(vrf_raddr_a), .vrf_raddr_b(vrf_raddr_b),
    .vrf_rdata_a(vrf_rdata_a), .vrf_rdata_b(vrf_rdata_b),
    .wb_vwe(wb_vwe), .wb_swe(wb_swe), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  assign vrf_rdata_a = vrf[vrf_raddr_a];
  assign vrf_rdata_b = vrf[vrf_raddr_b];
  assign mem_gnt = mem_req && (gnt_always || wait_cnt >= gnt_delay);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_req && !mem_gnt) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_gnt && !mem_we) mem_rdata <= mem_addr ^ 16'hA5C3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wb_vwe === 1'b1 || wb_swe === 1'b1) begin
      chk("wr_expected", 32'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        we_e = wq.pop_front();
        chk("wr_vwe", wb_vwe, !we_e.swe);
        chk("wr_swe", wb_swe, we_e.swe);
        chk("wr_addr", wb_addr, we_e.addr);
        chk("wr_data", wb_data, we_e.data);
        chk("wr_cycle", cyc - base_cyc, we_e.off);
      end
    end
    if (mem_req === 1'b1) begin
      chk("mem_expected", 32'(mq.size() != 0), 1);
      if (mq.size() != 0) begin
        me_e = mq[0];
        chk("mem_we", mem_we, me_e.we);
        chk("mem_addr", mem_addr, me_e.addr);
        chk("mem_wdata", mem_wdata, me_e.wdata);
        if (mem_gnt) begin
          chk("mem_cycle", cyc - base_cyc, me_e.off);
          mq.delete(0);
        end
      end
    end
  end

  task automatic exp_alu(input logic [3:0] op, input int a, input int b, input int t);
    logic [15:0] x, y, r;
    for (int k = 0; k < VL; k++) begin
      x = vrf[a*VL+k];
      y = vrf[b*VL+k];
      case (op)
        OP_VADD: r = x + y;
        OP_VSUB: r = x - y;
        default: r = x * y;
      endcase
      wq.push_back('{1'b0, AW'(t*VL+k), r, k+1});
    end
  endtask

  task automatic exp_dot(input int a, input int b, input int t);
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < VL; k++) acc = acc + vrf[a*VL+k] * vrf[b*VL+k];
    wq.push_back('{1'b1, AW'(t*VL), acc, VL+1});
  endtask

  task automatic exp_ld(input logic [15:0] base, input int t);
    logic [15:0] ad;
    for (int k = 0; k < VL; k++) begin
      ad = base + 16'(k);
      mq.push_back('{1'b0, ad, 16'h0, 4*k+3});
      wq.push_back('{1'b0, AW'(t*VL+k), ad ^ 16'hA5C3, 4*k+4});
    end
  endtask

  task automatic exp_st(input int a, input logic [15:0] base);
    for (int k = 0; k < VL; k++) mq.push_back('{1'b1, base + 16'(k), vrf[a*VL+k], k+1});
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] t, input logic [15:0] base);
    opcode = op; ra = a; rb = b; rt = t; base_addr = base; start = 1'b1;
    base_cyc = cyc;
    @(negedge clk);
    start = 1'b0; opcode = 4'hF; ra = ~a; rb = ~b; rt = ~t; base_addr = ~base;
  endtask

  task automatic wait_done(input string tag, input int exp_off);
    int off;
    off = cyc - base_cyc;
    while (done !== 1'b1 && off < 60) begin
      @(negedge clk);
      off = cyc - base_cyc;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, off, exp_off);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_drained"}, wq.size() + mq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 64; n++) vrf[n] = 16'(n * 37 + 5);
    vrf[4]  = 1;       vrf[5]  = 2;      vrf[6]  = 3;       vrf[7]  = 4;
    vrf[8]  = 10;      vrf[9]  = 20;     vrf[10] = 30;      vrf[11] = 40;
    vrf[16] = 5;       vrf[17] = 6;      vrf[18] = 7;       vrf[19] = 8;
    vrf[20] = 3;       vrf[21] = 100;    vrf[22] = 0;       vrf[23] = 16'hFFFF;
    vrf[24] = 5;       vrf[25] = 1;      vrf[26] = 1;       vrf[27] = 16'hFFFF;
    vrf[28] = 16'h0100; vrf[29] = 3;     vrf[30] = 16'hFFFF; vrf[31] = 16'h1234;
    vrf[32] = 16'h0100; vrf[33] = 7;     vrf[34] = 16'hFFFF; vrf[35] = 0;

    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_enables", {done, wb_vwe, wb_swe, mem_req, mem_we}, 0);
    chk("rst_addrs", {vrf_raddr_a, vrf_raddr_b, wb_addr}, 0);
    chk("rst_data", {wb_data, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    exp_alu(OP_VADD, 1, 2, 3);
    issue(OP_VADD, 1, 2, 3, 16'h0);
    wait_done("vadd", 5);

    exp_dot(1, 4, 9);
    chk("vdot_model", wq[0].data, 70);
    issue(OP_VDOT, 1, 4, 9, 16'h0);
    wait_done("vdot", 5);

    exp_alu(OP_VSUB, 5, 6, 13);
    issue(OP_VSUB, 5, 6, 13, 16'h0);
    wait_done("vsub", 5);

    exp_alu(OP_VMUL, 7, 8, 14);
    issue(OP_VMUL, 7, 8, 14, 16'h0);
    wait_done("vmul", 5);

    issue(OP_VDIV, 1, 2, 3, 16'h0);
    wait_done("vdiv", 1);

    issue(4'b0011, 1, 2, 3, 16'h0);
    wait_done("undef_op", 1);

    gnt_delay = 2;
    exp_ld(16'hFFFE, 10);
    issue(OP_VLD, 0, 0, 10, 16'hFFFE);
    wait_done("vld", 17);

    gnt_always = 1'b1;
    exp_st(2, 16'h0040);
    issue(OP_VST, 2, 0, 0, 16'h0040);
    wait_done("vst", 5);
    gnt_always = 1'b0;

    exp_alu(OP_VSUB, 5, 6, 15);
    issue(OP_VSUB, 5, 6, 15, 16'h0);
    start = 1'b1; opcode = OP_VADD; ra = 1; rb = 2; rt = 11;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 5);
    @(negedge clk);
    chk("busy_start_idle2", busy, 0);

    for (int k = 0; k < 2; k++) wq.push_back('{1'b0, AW'(12*VL+k), vrf[VL+k] + vrf[2*VL+k], k+1});
    issue(OP_VADD, 1, 2, 12, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_vwe", wb_vwe, 0);
    chk("abort_addr", {wb_addr, vrf_raddr_a}, 0);
    chk("abort_data", wb_data, 0);
    @(negedge clk);
    chk("abort_drained", wq.size(), 0);
    chk("abort_held", {busy, done, wb_vwe}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_alu(OP_VADD, 1, 2, 3);
    issue(OP_VADD, 1, 2, 3, 16'h0);
    wait_done("post_rst_vadd", 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
